// File: rtl/wasm_pkg.sv
`default_nettype none
// ============================================================================
// Module : wasm_pkg
// Brief  : Shared WebAssembly loader types: value types, const-expression
//          opcodes, global-section error codes, loader FSM states and
//          the valtype decode helper.
// Rev    : 1.0  initial release
// ============================================================================
package wasm_pkg;

    typedef enum logic [1:0] {
        VT_I32 = 2'd0,
        VT_I64 = 2'd1,
        VT_F32 = 2'd2,
        VT_F64 = 2'd3
    } valtype_e;

    localparam logic [7:0] VALTYPE_I32 = 8'h7F;
    localparam logic [7:0] VALTYPE_I64 = 8'h7E;
    localparam logic [7:0] VALTYPE_F32 = 8'h7D;
    localparam logic [7:0] VALTYPE_F64 = 8'h7C;

    localparam logic [7:0] OP_I32_CONST  = 8'h41;
    localparam logic [7:0] OP_I64_CONST  = 8'h42;
    localparam logic [7:0] OP_F32_CONST  = 8'h43;
    localparam logic [7:0] OP_F64_CONST  = 8'h44;
    localparam logic [7:0] OP_GLOBAL_GET = 8'h23;
    localparam logic [7:0] OP_END        = 8'h0B;

    typedef enum logic [2:0] {
        GSL_ERR_NONE        = 3'd0,
        GSL_ERR_BAD_VALTYPE = 3'd1,
        GSL_ERR_BAD_MUT     = 3'd2,
        GSL_ERR_BAD_OPCODE  = 3'd3,
        GSL_ERR_LEB_OVF     = 3'd4,
        GSL_ERR_MISSING_END = 3'd5,
        GSL_ERR_TOO_MANY    = 3'd6,
        GSL_ERR_BAD_GGET    = 3'd7
    } gsl_err_e;

    typedef enum logic [3:0] {
        GSL_IDLE    = 4'd0,
        GSL_COUNT   = 4'd1,
        GSL_VALTYPE = 4'd2,
        GSL_MUT     = 4'd3,
        GSL_OPCODE  = 4'd4,
        GSL_IMM     = 4'd5,
        GSL_END     = 4'd6,
        GSL_EMIT    = 4'd7,
        GSL_DONE    = 4'd8,
        GSL_ERR     = 4'd9,
        GSL_GIDX    = 4'd10,
        GSL_GGET    = 4'd11
    } gsl_state_e;

    typedef struct packed {
        valtype_e    vtype;
        logic        mutable_flag;
        logic [63:0] value;
    } global_entry_t;

    typedef struct packed {
        valtype_e    vtype;
        logic [63:0] value;
    } stack_entry_t;

    typedef struct packed {
        logic     valid;
        valtype_e vtype;
    } valtype_dec_t;

    function automatic valtype_dec_t decode_valtype(input logic [7:0] b);
        valtype_dec_t r;
        r.valid = 1'b1;
        r.vtype = VT_I32;
        case (b)
            VALTYPE_I32: r.vtype = VT_I32;
            VALTYPE_I64: r.vtype = VT_I64;
            VALTYPE_F32: r.vtype = VT_F32;
            VALTYPE_F64: r.vtype = VT_F64;
            default:     r.valid = 1'b0;
        endcase
        return r;
    endfunction

    // The only const opcode accepted for a given declared type.
    function automatic logic [7:0] const_opcode(input valtype_e vt);
        logic [7:0] op;
        case (vt)
            VT_I32:  op = OP_I32_CONST;
            VT_I64:  op = OP_I64_CONST;
            VT_F32:  op = OP_F32_CONST;
            default: op = OP_F64_CONST;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wasm_leb128_dec.sv
`default_nettype none
// ============================================================================
// Module : wasm_leb128_dec
// Brief  : Byte-serial unsigned/signed LEB128 accumulator.
//          value/last/overflow describe the byte currently strobed in, so the
//          consumer can capture the final value on the same edge it accepts
//          the last byte.
// Ports  : clk, rst_n        clock, async active-low reset
//          clear             restart accumulation (takes priority)
//          byte_en, byte_in  accepted byte strobe and data
//          is_signed         sign-extend from bit 6 of the final byte
//          max_bytes         longest legal encoding in bytes
//          value[63:0]       accumulated value including current byte
//          last              current byte terminates the encoding
//          overflow          current byte would require one more byte than allowed
// Rev    : 1.0  initial release
// ============================================================================
module wasm_leb128_dec (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    input  logic        is_signed,
    input  logic [3:0]  max_bytes,
    output logic [63:0] value,
    output logic        last,
    output logic        overflow
);

    logic [63:0] r_acc;
    logic [6:0]  r_shift;
    logic [3:0]  r_nbytes;
    logic [63:0] w_part;

    assign w_part = 64'(byte_in[6:0]) << r_shift;

    always_comb begin
        value = r_acc | w_part;
        // Shifts of 64 or more bits yield zero, so no extension past bit 63.
        if (is_signed && byte_in[6])
            value = value | (~64'd0 << (r_shift + 7'd7));
    end

    assign last     = byte_en & ~byte_in[7];
    assign overflow = byte_en & byte_in[7] & ((r_nbytes + 4'd1) == max_bytes);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_shift  <= '0;
            r_nbytes <= '0;
        end else if (clear) begin
            r_acc    <= '0;
            r_shift  <= '0;
            r_nbytes <= '0;
        end else if (byte_en) begin
            r_acc    <= r_acc | w_part;
            r_shift  <= r_shift + 7'd7;
            r_nbytes <= r_nbytes + 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wasm_global_section_loader.sv
`default_nettype none
// ============================================================================
// Module : wasm_global_section_loader
// Brief  : Streaming decoder for the WebAssembly Global section payload.
//          Parses vec(global) and writes each decoded global into the
//          globals store through a one-cycle init strobe.
// Config : GLOBAL_GET_INIT_EN - accept global.get init expressions; adds
//          the rd_en/rd_idx/rd_data/rd_valid read port into the store.
// Ports  : clk, rst_n                clock, async active-low reset
//          start                     begin new payload (ignored while busy)
//          in_valid/in_data/in_ready byte stream handshake
//          init_en/init_idx/init_data globals store write port
//          busy, done, error, err_code status
//          loaded                    globals emitted so far
// Rev    : 1.0  initial release
// ============================================================================
module wasm_global_section_loader
    import wasm_pkg::*;
#(
    parameter int MAX_GLOBALS = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          init_en,
    output logic [7:0]    init_idx,
    output global_entry_t init_data,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [2:0]    err_code,
`ifdef GLOBAL_GET_INIT_EN
    output logic          rd_en,
    output logic [7:0]    rd_idx,
    input  stack_entry_t  rd_data,
    input  logic          rd_valid,
`endif
    output logic [8:0]    loaded
);

    gsl_state_e  r_state, state_nx;
    logic [8:0]  r_count, count_nx;
    logic [8:0]  r_loaded, loaded_nx;
    valtype_e    r_vtype, vtype_nx;
    logic        r_mut, mut_nx;
    logic [63:0] r_value, value_nx;
    logic [3:0]  r_rawcnt, rawcnt_nx;
    gsl_err_e    r_err, err_nx;
`ifdef GLOBAL_GET_INIT_EN
    logic [7:0]  r_gidx, gidx_nx;
`endif

    logic         w_acc;
    logic         leb_clear, leb_en, leb_signed;
    logic [3:0]   leb_max;
    logic [63:0]  leb_value;
    logic         leb_last, leb_ovf;
    valtype_dec_t w_vt;
    logic         w_is_float;
    logic [3:0]   w_raw_last;

    assign w_acc      = in_valid & in_ready;
    assign w_vt       = decode_valtype(in_data);
    assign w_is_float = (r_vtype == VT_F32) || (r_vtype == VT_F64);
    assign w_raw_last = (r_vtype == VT_F32) ? 4'd3 : 4'd7;

    wasm_leb128_dec u_leb (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (leb_clear),
        .byte_en   (leb_en),
        .byte_in   (in_data),
        .is_signed (leb_signed),
        .max_bytes (leb_max),
        .value     (leb_value),
        .last      (leb_last),
        .overflow  (leb_ovf)
    );

    assign init_idx  = r_loaded[7:0];
    assign init_data = {r_vtype, r_mut, r_value};
    assign loaded    = r_loaded;
    assign error     = (r_state == GSL_ERR);
    assign err_code  = r_err;
`ifdef GLOBAL_GET_INIT_EN
    assign rd_idx    = r_gidx;
`endif

    always_comb begin
        state_nx   = r_state;
        count_nx   = r_count;
        loaded_nx  = r_loaded;
        vtype_nx   = r_vtype;
        mut_nx     = r_mut;
        value_nx   = r_value;
        rawcnt_nx  = r_rawcnt;
        err_nx     = r_err;
`ifdef GLOBAL_GET_INIT_EN
        gidx_nx    = r_gidx;
        rd_en      = 1'b0;
`endif
        in_ready   = 1'b0;
        init_en    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        leb_clear  = 1'b1;
        leb_en     = 1'b0;
        leb_signed = 1'b0;
        leb_max    = 4'd5;

        case (r_state)
            GSL_IDLE, GSL_DONE, GSL_ERR: begin
                busy = 1'b0;
                done = (r_state == GSL_DONE);
                if (r_state == GSL_DONE)
                    state_nx = GSL_IDLE;
                if (start) begin
                    state_nx  = GSL_COUNT;
                    loaded_nx = '0;
                    err_nx    = GSL_ERR_NONE;
                end
            end

            GSL_COUNT: begin
                in_ready  = 1'b1;
                leb_clear = 1'b0;
                leb_en    = w_acc;
                if (leb_ovf) begin
                    state_nx = GSL_ERR;
                    err_nx   = GSL_ERR_LEB_OVF;
                end else if (leb_last) begin
                    if (leb_value > 64'(MAX_GLOBALS)) begin
                        state_nx = GSL_ERR;
                        err_nx   = GSL_ERR_TOO_MANY;
                    end else if (leb_value == 64'd0) begin
                        state_nx = GSL_DONE;
                    end else begin
                        count_nx = leb_value[8:0];
                        state_nx = GSL_VALTYPE;
                    end
                end
            end

            GSL_VALTYPE: begin
                in_ready = 1'b1;
                if (w_acc) begin
                    if (w_vt.valid) begin
                        vtype_nx = w_vt.vtype;
                        state_nx = GSL_MUT;
                    end else begin
                        state_nx = GSL_ERR;
                        err_nx   = GSL_ERR_BAD_VALTYPE;
                    end
                end
            end

            GSL_MUT: begin
                in_ready = 1'b1;
                if (w_acc) begin
                    if (in_data[7:1] == 7'd0) begin
                        mut_nx   = in_data[0];
                        state_nx = GSL_OPCODE;
                    end else begin
                        state_nx = GSL_ERR;
                        err_nx   = GSL_ERR_BAD_MUT;
                    end
                end
            end

            GSL_OPCODE: begin
                in_ready = 1'b1;
                if (w_acc) begin
                    value_nx  = '0;
                    rawcnt_nx = '0;
                    if (in_data == const_opcode(r_vtype)) begin
                        state_nx = GSL_IMM;
`ifdef GLOBAL_GET_INIT_EN
                    end else if (in_data == OP_GLOBAL_GET) begin
                        state_nx = GSL_GIDX;
`endif
                    end else begin
                        state_nx = GSL_ERR;
                        err_nx   = GSL_ERR_BAD_OPCODE;
                    end
                end
            end

            GSL_IMM: begin
                in_ready = 1'b1;
                if (w_is_float) begin
                    // Float immediates are raw little-endian bytes.
                    if (w_acc) begin
                        value_nx  = r_value | (64'(in_data) << {r_rawcnt[2:0], 3'b000});
                        rawcnt_nx = r_rawcnt + 4'd1;
                        if (r_rawcnt == w_raw_last)
                            state_nx = GSL_END;
                    end
                end else begin
                    leb_clear  = 1'b0;
                    leb_en     = w_acc;
                    leb_signed = 1'b1;
                    leb_max    = (r_vtype == VT_I64) ? 4'd10 : 4'd5;
                    if (leb_ovf) begin
                        state_nx = GSL_ERR;
                        err_nx   = GSL_ERR_LEB_OVF;
                    end else if (leb_last) begin
                        value_nx = (r_vtype == VT_I64) ? leb_value
                                                       : {32'd0, leb_value[31:0]};
                        state_nx = GSL_END;
                    end
                end
            end

`ifdef GLOBAL_GET_INIT_EN
            GSL_GIDX: begin
                in_ready  = 1'b1;
                leb_clear = 1'b0;
                leb_en    = w_acc;
                if (leb_ovf) begin
                    state_nx = GSL_ERR;
                    err_nx   = GSL_ERR_LEB_OVF;
                end else if (leb_last) begin
                    // Only globals already written to the store may be read.
                    if (leb_value >= 64'(r_loaded)) begin
                        state_nx = GSL_ERR;
                        err_nx   = GSL_ERR_BAD_GGET;
                    end else begin
                        gidx_nx  = leb_value[7:0];
                        state_nx = GSL_GGET;
                    end
                end
            end

            GSL_GGET: begin
                rd_en = 1'b1;
                if (!rd_valid || (rd_data.vtype != r_vtype)) begin
                    state_nx = GSL_ERR;
                    err_nx   = GSL_ERR_BAD_GGET;
                end else begin
                    value_nx = w_is_float && (r_vtype == VT_F32) || (r_vtype == VT_I32)
                             ? {32'd0, rd_data.value[31:0]} : rd_data.value;
                    state_nx = GSL_END;
                end
            end
`endif

            GSL_END: begin
                in_ready = 1'b1;
                if (w_acc) begin
                    if (in_data == OP_END) begin
                        state_nx = GSL_EMIT;
                    end else begin
                        state_nx = GSL_ERR;
                        err_nx   = GSL_ERR_MISSING_END;
                    end
                end
            end

            GSL_EMIT: begin
                init_en   = 1'b1;
                loaded_nx = r_loaded + 9'd1;
                state_nx  = ((r_loaded + 9'd1) < r_count) ? GSL_VALTYPE : GSL_DONE;
            end

            default: state_nx = GSL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= GSL_IDLE;
            r_count  <= '0;
            r_loaded <= '0;
            r_vtype  <= VT_I32;
            r_mut    <= 1'b0;
            r_value  <= '0;
            r_rawcnt <= '0;
            r_err    <= GSL_ERR_NONE;
`ifdef GLOBAL_GET_INIT_EN
            r_gidx   <= '0;
`endif
        end else begin
            r_state  <= state_nx;
            r_count  <= count_nx;
            r_loaded <= loaded_nx;
            r_vtype  <= vtype_nx;
            r_mut    <= mut_nx;
            r_value  <= value_nx;
            r_rawcnt <= rawcnt_nx;
            r_err    <= err_nx;
`ifdef GLOBAL_GET_INIT_EN
            r_gidx   <= gidx_nx;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wasm_global_section_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_wasm_global_section_loader
// Brief  : Self-checking bench for wasm_global_section_loader. Sections are
//          built from lists of globals (encoded here) and fed with random
//          in_valid gaps; every init strobe is compared with the list.
// Rev    : 1.0  initial release
// ============================================================================
module tb_wasm_global_section_loader;
    import wasm_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready, init_en, busy, done, error;
    logic [7:0]    init_idx;
    global_entry_t init_data;
    logic [2:0]    err_code;
    logic [8:0]    loaded;
`ifdef GLOBAL_GET_INIT_EN
    logic          rd_en;
    logic [7:0]    rd_idx;
    stack_entry_t  rd_data;
    logic          rd_valid;
    stack_entry_t  store [256];
`endif

    always #5 clk = ~clk;

    wasm_global_section_loader #(.MAX_GLOBALS(256)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .init_en   (init_en),
        .init_idx  (init_idx),
        .init_data (init_data),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code),
`ifdef GLOBAL_GET_INIT_EN
        .rd_en     (rd_en),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
`endif
        .loaded    (loaded)
    );

`ifdef GLOBAL_GET_INIT_EN
    // Minimal globals store behind the init and read ports.
    always @(posedge clk)
        if (init_en) store[init_idx] <= '{vtype: init_data.vtype, value: init_data.value};
    assign rd_data  = store[rd_idx];
    assign rd_valid = 1'b1;
`endif

    typedef struct {
        logic [1:0]  vt;
        logic        mut;
        logic [63:0] val;
    } exp_t;

    logic [7:0] bq[$];
    exp_t       exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void push_bytes(input logic [7:0] b[]);
        foreach (b[i]) bq.push_back(b[i]);
    endfunction

    function automatic void push_uleb(input longint unsigned v);
        logic [7:0] b;
        do begin
            b = {1'b0, v[6:0]};
            v = v >> 7;
            if (v != 0) b[7] = 1'b1;
            bq.push_back(b);
        end while (v != 0);
    endfunction

    function automatic void push_sleb(input longint v);
        logic [7:0] b;
        bit more;
        do begin
            b    = {1'b0, v[6:0]};
            v    = v >>> 7;
            more = !((v == 0 && !b[6]) || (v == -1 && b[6]));
            b[7] = more;
            bq.push_back(b);
        end while (more);
    endfunction

    // Encode one global from its declared type/mutability/value and record
    // what the store must receive for it.
    function automatic void add_global(input int vt, input bit mut, input logic [63:0] v);
        exp_t e;
        logic [7:0] tbyte [4] = '{8'h7F, 8'h7E, 8'h7D, 8'h7C};
        bq.push_back(tbyte[vt]);
        bq.push_back({7'd0, mut});
        bq.push_back(8'(8'h41 + vt));
        case (vt)
            0: push_sleb(longint'($signed(v[31:0])));
            1: push_sleb(longint'(v));
            2: for (int k = 0; k < 4; k++) bq.push_back(v[8*k +: 8]);
            default: for (int k = 0; k < 8; k++) bq.push_back(v[8*k +: 8]);
        endcase
        bq.push_back(8'h0B);
        e.vt  = 2'(vt);
        e.mut = mut;
        e.val = (vt == 0 || vt == 2) ? {32'd0, v[31:0]} : v;
        exp_q.push_back(e);
    endfunction

    function automatic void clear_case();
        bq.delete();
        exp_q.delete();
    endfunction

    function automatic logic [63:0] rand_value(input int vt);
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 4))
            0: v = 64'd0;
            1: v = '1;
            2: v = (vt == 1) ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
            3: v = 64'(6'($urandom));
            default: ;
        endcase
        return v;
    endfunction

    function automatic void gen_random(input int n);
        clear_case();
        if (n < 128 && $urandom_range(0, 2) == 0)
            push_bytes('{8'(n) | 8'h80, 8'h00});
        else
            push_uleb(longint'(n));
        for (int g = 0; g < n; g++) begin
            int vt;
            vt = $urandom_range(0, 3);
            add_global(vt, 1'($urandom), rand_value(vt));
        end
    endfunction

    task automatic run_section(input string name, input int exp_err);
        int idx, got, cyc;
        bit fin;
        exp_t e;
        idx = 0; got = 0; cyc = 0; fin = 0;
        @(negedge clk);
        start = 1'b1;
        check({name, ":ready_at_start"}, 128'(in_ready), 128'(0));
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (init_en) begin
                if (got < exp_q.size()) begin
                    e = exp_q[got];
                    check({name, ":init_idx"}, 128'(init_idx), 128'(got));
                    check({name, ":init_data"}, 128'(init_data), 128'({e.vt, e.mut, e.val}));
                end else begin
                    check({name, ":extra_init"}, 128'(1), 128'(0));
                end
                got++;
            end
            if (done || error) fin = 1;
            if (!fin && idx < bq.size()) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = bq[idx];
                if (in_valid && in_ready) idx++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        if (!fin) check({name, ":timeout"}, 128'(0), 128'(1));
        check({name, ":n_init"}, 128'(got), 128'(exp_q.size()));
        check({name, ":error"}, 128'(error), 128'(exp_err != 0));
        check({name, ":err_code"}, 128'(err_code), 128'(exp_err));
        check({name, ":busy"}, 128'(busy), 128'(0));
        if (exp_err == 0) begin
            check({name, ":loaded"}, 128'(loaded), 128'(exp_q.size()));
            check({name, ":consumed"}, 128'(idx), 128'(bq.size()));
            @(negedge clk);
            check({name, ":done_pulse"}, 128'(done), 128'(0));
        end else begin
            check({name, ":err_ready"}, 128'(in_ready), 128'(0));
            @(negedge clk);
            check({name, ":err_sticky"}, 128'(error), 128'(1));
            check({name, ":err_no_init"}, 128'(init_en), 128'(0));
        end
    endtask

    initial begin
        int gget_err;
`ifdef GLOBAL_GET_INIT_EN
        gget_err = 7;
`else
        gget_err = 3;
`endif
        repeat (3) @(negedge clk);
        check("rst:busy", 128'(busy), 128'(0));
        check("rst:in_ready", 128'(in_ready), 128'(0));
        check("rst:error", 128'(error), 128'(0));
        check("rst:loaded", 128'(loaded), 128'(0));
        check("rst:init_data", 128'(init_data), 128'(0));
        rst_n = 1'b1;

        clear_case(); push_bytes('{8'h01, 8'h7F, 8'h00, 8'h41, 8'h2A, 8'h0B});
        exp_q.push_back('{2'd0, 1'b0, 64'h2A});
        run_section("t1_i32", 0);

        clear_case(); push_bytes('{8'h01, 8'h7F, 8'h01, 8'h41, 8'h7F, 8'h0B});
        exp_q.push_back('{2'd0, 1'b1, 64'h0000_0000_FFFF_FFFF});
        run_section("t2_i32neg", 0);

        clear_case();
        push_bytes('{8'h01, 8'h7C, 8'h00, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 8'hF0, 8'h3F, 8'h0B});
        exp_q.push_back('{2'd3, 1'b0, 64'h3FF0_0000_0000_0000});
        run_section("t3_f64", 0);

        clear_case();
        push_bytes('{8'h02, 8'h7E, 8'h00, 8'h42, 8'h80, 8'h7F, 8'h0B,
                     8'h7D, 8'h01, 8'h43, 8'h00, 8'h00, 8'h80, 8'h3F, 8'h0B});
        exp_q.push_back('{2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FF80});
        exp_q.push_back('{2'd2, 1'b1, 64'h3F80_0000});
        run_section("t3_i64_f32", 0);

        clear_case(); push_bytes('{8'h00});
        run_section("count0", 0);

        clear_case(); push_bytes('{8'h01, 8'h7F, 8'h00, 8'h42, 8'h01, 8'h0B});
        run_section("e3_mismatch", 3);
        clear_case(); push_bytes('{8'h01, 8'h7F, 8'h02});
        run_section("e2_mut", 2);
        clear_case(); push_bytes('{8'h01, 8'h7F, 8'h00, 8'h41, 8'h01, 8'h0C});
        run_section("e5_end", 5);
        clear_case(); push_bytes('{8'h01, 8'h7F, 8'h00, 8'h41, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF});
        run_section("e4_sleb", 4);
        clear_case(); push_bytes('{8'h81, 8'h02});
        run_section("e6_count", 6);
        clear_case(); push_bytes('{8'h01, 8'h70});
        run_section("e1_valtype", 1);
        clear_case(); push_bytes('{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80});
        run_section("e4_count", 4);
        clear_case(); push_bytes('{8'h01, 8'h7F, 8'h00, 8'h23, 8'h00, 8'h0B});
        run_section("e_gget0", gget_err);
        clear_case();
        push_bytes('{8'h02, 8'h7F, 8'h00, 8'h41, 8'h01, 8'h0B, 8'h7F, 8'h00, 8'h41, 8'h01, 8'h0C});
        exp_q.push_back('{2'd0, 1'b0, 64'h1});
        run_section("e5_second", 5);

        gen_random(256);
        run_section("max_count", 0);
        for (int r = 0; r < 12; r++) begin
            gen_random($urandom_range(1, 8));
            run_section("random", 0);
        end

        // Reset in the middle of an f64 immediate.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        foreach (bq[i]) bq.delete(i);
        push_bytes('{8'h01, 8'h7C, 8'h01, 8'h44, 8'h11, 8'h22});
        for (int i = 0; i < 6; i++) begin
            check("mid:ready", 128'(in_ready), 128'(1));
            in_valid = 1'b1;
            in_data  = bq[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst:busy", 128'(busy), 128'(0));
        check("mid_rst:in_ready", 128'(in_ready), 128'(0));
        check("mid_rst:init_en", 128'(init_en), 128'(0));
        check("mid_rst:done", 128'(done), 128'(0));
        check("mid_rst:error", 128'({error, err_code}), 128'(0));
        check("mid_rst:loaded", 128'(loaded), 128'(0));
        check("mid_rst:init_idx", 128'(init_idx), 128'(0));
        check("mid_rst:init_data", 128'(init_data), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("post_rst:idle", 128'({busy, init_en, in_ready}), 128'(0));
        end
        clear_case(); push_bytes('{8'h01, 8'h7F, 8'h00, 8'h41, 8'h2A, 8'h0B});
        exp_q.push_back('{2'd0, 1'b0, 64'h2A});
        run_section("restart", 0);

`ifdef GLOBAL_GET_INIT_EN
        clear_case();
        push_bytes('{8'h02, 8'h7F, 8'h00, 8'h41, 8'h05, 8'h0B, 8'h7F, 8'h00, 8'h23, 8'h00, 8'h0B});
        exp_q.push_back('{2'd0, 1'b0, 64'h5});
        exp_q.push_back('{2'd0, 1'b0, 64'h5});
        run_section("gget_ok", 0);
        clear_case();
        push_bytes('{8'h02, 8'h7F, 8'h00, 8'h41, 8'h05, 8'h0B, 8'h7F, 8'h00, 8'h23, 8'h01, 8'h0B});
        exp_q.push_back('{2'd0, 1'b0, 64'h5});
        run_section("gget_idx", 7);
        clear_case();
        push_bytes('{8'h02, 8'h7E, 8'h00, 8'h42, 8'h05, 8'h0B, 8'h7F, 8'h00, 8'h23, 8'h00, 8'h0B});
        exp_q.push_back('{2'd1, 1'b0, 64'h5});
        run_section("gget_type", 7);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
